reg_delay_line: RTL



---
 rtl/reg_pkg.sv | 19 +
 rtl/reg_stage.sv | 29 ++
 rtl/reg_delay_line.sv | 68 ++++++
 3 files changed

// File: rtl/reg_pkg.sv
// reg_pkg: shared constants and helpers for the register/memory-element blocks.
// Contents: REG_RESET_VAL (common reset/flush data value), clog2_cnt() to size
// an occupancy counter that must represent 0..depth inclusive.
package reg_pkg;

  // Data value every memory-element block loads on reset and flush.
  localparam int unsigned REG_RESET_VAL = 0;

  // Bits needed to hold the values 0..depth (note: depth itself, not depth-1).
  function automatic int clog2_cnt(input int depth);
    int w;
    w = 0;
    while ((1 << w) < (depth + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/reg_stage.sv
// reg_stage: one pipeline stage, a WIDTH-bit data register plus its valid flop.
// Ports: CLK, RST (sync, active-high), CLR (sync clear), EN (load enable),
//        d/d_vld in, q/q_vld out. RST and CLR both load RESET_VAL and clear q_vld.
module reg_stage #(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             EN,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      q     <= RESET_VAL;
      q_vld <= 1'b0;
    end else if (EN) begin
      // Data moves regardless of d_vld: invalid slots are not squashed.
      q     <= d;
      q_vld <= d_vld;
    end
  end

endmodule

// File: rtl/reg_delay_line.sv
// reg_delay_line: DEPTH-stage, WIDTH-bit fixed-latency delay line with per-stage
// valid, global advance enable (EN), synchronous FLUSH and live occupancy COUNT.
// Ports: CLK, RST, EN, D, D_VALID, FLUSH in; Q, Q_VALID, COUNT out (all registered).
module reg_delay_line
  import reg_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter int unsigned      DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(REG_RESET_VAL),
  localparam int unsigned     CNT_W     = clog2_cnt(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] D,
  input  logic             D_VALID,
  input  logic             FLUSH,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic [CNT_W-1:0] COUNT
);

  logic [DEPTH-1:0][WIDTH-1:0] stage_dat;
  logic [DEPTH-1:0]            stage_vld;
  logic [CNT_W-1:0]            cnt;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      reg_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (FLUSH),
        .EN    (EN),
        .d     (D),
        .d_vld (D_VALID),
        .q     (stage_dat[i]),
        .q_vld (stage_vld[i])
      );
    end else begin : g_body
      reg_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
        .CLK   (CLK),
        .RST   (RST),
        .CLR   (FLUSH),
        .EN    (EN),
        .d     (stage_dat[i-1]),
        .d_vld (stage_vld[i-1]),
        .q     (stage_dat[i]),
        .q_vld (stage_vld[i])
      );
    end
  end

  // Occupancy tracks popcount(stage_vld) incrementally: one word enters and one
  // leaves per advance. The true result is always 0..DEPTH, so modular CNT_W
  // arithmetic on the intermediate sum is exact.
  always_ff @(posedge CLK) begin
    if (RST || FLUSH) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= cnt + CNT_W'(D_VALID) - CNT_W'(stage_vld[DEPTH-1]);
    end
  end

  assign Q       = stage_dat[DEPTH-1];
  assign Q_VALID = stage_vld[DEPTH-1];
  assign COUNT   = cnt;

endmodule
